// File: rtl/updown_count_ctrl.sv
// Command sequencer for an up/down counter: load or N-step count commands over valid/ready.
// Steps once per RUN cycle, reports done with terminal-hit and abort status.
module updown_count_ctrl #(
  parameter int SIZE  = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [SIZE-1:0]  cmd_load_val,
  input  logic             cmd_up,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_wrap,
  input  logic             abort,
  output logic [SIZE-1:0]  q,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SIZE-1:0]  q_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             up, up_nxt;
  logic             wrap, wrap_nxt;
  logic             hit_r, hit_nxt;
  logic             aborted_r, aborted_nxt;

  logic             accept;
  logic [SIZE-1:0]  term_val;
  logic [SIZE-1:0]  wrap_val;
  logic [SIZE-1:0]  step_val;
  logic             last_step;

  // Terminal is all-ones counting up and zero counting down; wrapping lands on the opposite end.
  assign term_val  = up ? {SIZE{1'b1}} : {SIZE{1'b0}};
  assign wrap_val  = up ? {SIZE{1'b0}} : {SIZE{1'b1}};
  assign step_val  = up ? (q + SIZE'(1)) : (q - SIZE'(1));
  assign last_step = (rem == LEN_W'(1));
  assign accept    = cmd_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      rem       <= '0;
      up        <= 1'b0;
      wrap      <= 1'b0;
      hit_r     <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      q         <= q_nxt;
      rem       <= rem_nxt;
      up        <= up_nxt;
      wrap      <= wrap_nxt;
      hit_r     <= hit_nxt;
      aborted_r <= aborted_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    q_nxt       = q;
    rem_nxt     = rem;
    up_nxt      = up;
    wrap_nxt    = wrap;
    hit_nxt     = hit_r;
    aborted_nxt = aborted_r;

    case (state)
      IDLE: begin
        if (accept) begin
          hit_nxt     = 1'b0;
          aborted_nxt = 1'b0;
          if (cmd_load) begin
            q_nxt     = cmd_load_val;
            state_nxt = DONE;
          end else if (cmd_len == '0) begin
            state_nxt = DONE;
          end else begin
            up_nxt    = cmd_up;
            wrap_nxt  = cmd_wrap;
            rem_nxt   = cmd_len;
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          rem_nxt = rem - LEN_W'(1);
          if (q == term_val) begin
            hit_nxt = 1'b1;
            if (wrap) begin
              q_nxt = wrap_val;
              if (last_step) state_nxt = DONE;
            end else begin
              // Saturating count parked on the terminal ends the command early.
              state_nxt = DONE;
            end
          end else begin
            q_nxt = step_val;
            if (step_val == term_val) hit_nxt = 1'b1;
            if (last_step) state_nxt = DONE;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags are only meaningful once a command has finished, so hide them while running.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == RUN) || (state == DONE);
    done      = (state == DONE);
    hit       = hit_r && (state != RUN);
    aborted   = aborted_r && (state != RUN);
  end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl: vector table for load/count/wrap/saturate flows,
// plus hand sequences for reset mid-run and abort with a held command.
module tb_updown_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_load_val;
  logic       cmd_up;
  logic [7:0] cmd_len;
  logic       cmd_wrap;
  logic       abort;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       hit;
  logic       aborted;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_count_ctrl #(.SIZE(4), .LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load     (cmd_load),
    .cmd_load_val (cmd_load_val),
    .cmd_up       (cmd_up),
    .cmd_len      (cmd_len),
    .cmd_wrap     (cmd_wrap),
    .abort        (abort),
    .q            (q),
    .busy         (busy),
    .done         (done),
    .hit          (hit),
    .aborted      (aborted)
  );

  typedef struct {
    logic       vld;
    logic       ld;
    logic [3:0] lval;
    logic       up;
    logic [7:0] len;
    logic       wrap;
    logic       ab;
    logic [3:0] eq;
    logic       erdy;
    logic       ebusy;
    logic       edone;
    logic       ehit;
    logic       eabt;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic vld, input logic ld, input logic [3:0] lval,
                              input logic up, input logic [7:0] len, input logic wrap,
                              input logic ab, input logic [3:0] eq, input logic erdy,
                              input logic ebusy, input logic edone, input logic ehit,
                              input logic eabt);
    vec_t v;
    v.vld = vld; v.ld = ld; v.lval = lval; v.up = up; v.len = len; v.wrap = wrap; v.ab = ab;
    v.eq = eq; v.erdy = erdy; v.ebusy = ebusy; v.edone = edone; v.ehit = ehit; v.eabt = eabt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eq, input logic erdy,
                            input logic ebusy, input logic edone, input logic ehit,
                            input logic eabt);
    chk({tag, ".q"},         32'(q),         32'(eq));
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(erdy));
    chk({tag, ".busy"},      32'(busy),      32'(ebusy));
    chk({tag, ".done"},      32'(done),      32'(edone));
    chk({tag, ".hit"},       32'(hit),       32'(ehit));
    chk({tag, ".aborted"},   32'(aborted),   32'(eabt));
  endtask

  task automatic drive(input logic vld, input logic ld, input logic [3:0] lval, input logic up,
                       input logic [7:0] len, input logic wrap, input logic ab);
    cmd_valid    = vld;
    cmd_load     = ld;
    cmd_load_val = lval;
    cmd_up       = up;
    cmd_len      = len;
    cmd_wrap     = wrap;
    abort        = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Load C, count up 3 with wrap: C,D,E,F, hit on landing at F.
    tbl[0]  = mk(1,1,4'hC,0,8'd0,0,0,  4'hC,0,1,1,0,0);
    tbl[1]  = mk(0,0,4'h0,0,8'd0,0,0,  4'hC,1,0,0,0,0);
    tbl[2]  = mk(1,0,4'h0,1,8'd3,1,0,  4'hC,0,1,0,0,0);
    tbl[3]  = mk(0,0,4'h0,0,8'd0,0,0,  4'hD,0,1,0,0,0);
    tbl[4]  = mk(0,0,4'h0,0,8'd0,0,0,  4'hE,0,1,0,0,0);
    tbl[5]  = mk(0,0,4'h0,0,8'd0,0,0,  4'hF,0,1,1,1,0);
    tbl[6]  = mk(0,0,4'h0,0,8'd0,0,0,  4'hF,1,0,0,1,0);
    // Load E, saturating up 5: F then hold, done after two RUN cycles.
    tbl[7]  = mk(1,1,4'hE,0,8'd0,0,0,  4'hE,0,1,1,0,0);
    tbl[8]  = mk(0,0,4'h0,0,8'd0,0,0,  4'hE,1,0,0,0,0);
    tbl[9]  = mk(1,0,4'h0,1,8'd5,0,0,  4'hE,0,1,0,0,0);
    tbl[10] = mk(0,0,4'h0,0,8'd0,0,0,  4'hF,0,1,0,0,0);
    tbl[11] = mk(0,0,4'h0,0,8'd0,0,0,  4'hF,0,1,1,1,0);
    tbl[12] = mk(0,0,4'h0,0,8'd0,0,0,  4'hF,1,0,0,1,0);
    // Load 2, down 4 with wrap: 1,0,F,E.
    tbl[13] = mk(1,1,4'h2,0,8'd0,0,0,  4'h2,0,1,1,0,0);
    tbl[14] = mk(0,0,4'h0,0,8'd0,0,0,  4'h2,1,0,0,0,0);
    tbl[15] = mk(1,0,4'h0,0,8'd4,1,0,  4'h2,0,1,0,0,0);
    tbl[16] = mk(0,0,4'h0,0,8'd0,0,0,  4'h1,0,1,0,0,0);
    tbl[17] = mk(0,0,4'h0,0,8'd0,0,0,  4'h0,0,1,0,0,0);
    tbl[18] = mk(0,0,4'h0,0,8'd0,0,0,  4'hF,0,1,0,0,0);
    tbl[19] = mk(1,0,4'h0,0,8'd0,0,0,  4'hE,0,1,1,1,0);
    // Zero-length command offered during DONE is ignored, then accepted in IDLE.
    tbl[20] = mk(1,0,4'h0,0,8'd0,0,0,  4'hE,1,0,0,1,0);
    tbl[21] = mk(1,0,4'h0,0,8'd0,0,0,  4'hE,0,1,1,0,0);
    tbl[22] = mk(0,0,4'h0,0,8'd0,0,1,  4'hE,1,0,0,0,0);

    rst_n = 1'b0;
    drive(0, 0, 4'h0, 0, 8'd0, 0, 0);
    tick();
    tick();
    expect_out("reset", 4'h0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].vld, tbl[i].ld, tbl[i].lval, tbl[i].up, tbl[i].len, tbl[i].wrap, tbl[i].ab);
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].eq, tbl[i].erdy, tbl[i].ebusy,
                 tbl[i].edone, tbl[i].ehit, tbl[i].eabt);
    end

    // Abort on the third RUN cycle of an up-8 count; the command is held valid throughout.
    drive(1, 1, 4'h0, 0, 8'd0, 0, 0);
    tick();
    expect_out("ab_load", 4'h0, 0, 1, 1, 0, 0);
    drive(0, 0, 4'h0, 0, 8'd0, 0, 0);
    tick();
    drive(1, 0, 4'h0, 1, 8'd8, 0, 0);
    tick();
    expect_out("ab_run0", 4'h0, 0, 1, 0, 0, 0);
    tick();
    expect_out("ab_run1", 4'h1, 0, 1, 0, 0, 0);
    tick();
    expect_out("ab_run2", 4'h2, 0, 1, 0, 0, 0);
    abort = 1'b1;
    tick();
    expect_out("ab_done", 4'h2, 0, 1, 1, 0, 1);
    abort = 1'b0;
    tick();
    expect_out("ab_idle", 4'h2, 1, 0, 0, 0, 1);
    tick();
    expect_out("ab_reaccept", 4'h2, 0, 1, 0, 0, 0);
    drive(0, 0, 4'h0, 0, 8'd0, 0, 1);
    tick();
    expect_out("ab_done2", 4'h2, 0, 1, 1, 0, 1);
    abort = 1'b0;
    tick();
    expect_out("ab_idle2", 4'h2, 1, 0, 0, 0, 1);

    // Reset while counting up 10: killed command must not produce done.
    drive(1, 0, 4'h0, 1, 8'd10, 1, 0);
    tick();
    drive(0, 0, 4'h0, 0, 8'd0, 0, 0);
    tick();
    tick();
    expect_out("rst_pre", 4'h4, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    expect_out("rst_mid", 4'h0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("rst_after%0d", k), 4'h0, 1, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
